// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue and hazard control for the PSIMD DLFloat FPU.
// Takes one decoded instruction per cycle over valid/ready. It stalls on
// RAW/WAW scoreboard hazards, a busy divide/sqrt unit and writeback-port
// conflicts. Each accepted instruction produces a registered one-cycle issue
// pulse, and its writeback is sequenced through a 16-slot timeline.
// Ports:
//   clk, rst_n, flush         clock, async active-low reset, sync flush
//   dec_valid / dec_ready     decoder handshake (dec_ready is combinational)
//   dec_ena, dec_op, dec_sel1, dec_sel2, dec_rm   unit select and sub-op fields
//   dec_rs1..3, dec_rd, dec_wr_en                 register addresses / write enable
//   iss_valid, iss_*          issue pulse and registered copies of the fields
//   wb_valid, wb_rd           register-file write strobe and address
//   illegal                   one-cycle pulse when an illegal ena is consumed
module fpu_issue_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int FMA_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       dec_valid,
  output logic       dec_ready,
  input  logic [3:0] dec_ena,
  input  logic       dec_op,
  input  logic [1:0] dec_sel1,
  input  logic [2:0] dec_sel2,
  input  logic [2:0] dec_rm,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic [4:0] dec_rs3,
  input  logic [4:0] dec_rd,
  input  logic       dec_wr_en,
  output logic       iss_valid,
  output logic [3:0] iss_ena,
  output logic       iss_op,
  output logic [1:0] iss_sel1,
  output logic [2:0] iss_sel2,
  output logic [2:0] iss_rm,
  output logic [4:0] iss_rs1,
  output logic [4:0] iss_rs2,
  output logic [4:0] iss_rs3,
  output logic [4:0] iss_rd,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic       illegal
);

  function automatic logic [3:0] lat_of(input logic [3:0] ena);
    case (ena)
      4'b0001: lat_of = 4'd2;
      4'b0010: lat_of = 4'(MUL_LAT);
      4'b0011: lat_of = 4'(DIV_LAT);
      4'b0100: lat_of = 4'(DIV_LAT);
      4'b0101: lat_of = 4'd1;
      4'b0110: lat_of = 4'd1;
      4'b0111: lat_of = 4'd2;
      4'b1000: lat_of = 4'd2;
      4'b1001: lat_of = 4'(FMA_LAT);
      default: lat_of = 4'd0;
    endcase
  endfunction

  logic [31:0] pend;
  logic [15:0] slot_v;
  logic [4:0]  slot_rd [16];
  logic [3:0]  div_cnt;

  logic        legal, use_rs2, use_rs3, is_div;
  logic        raw, waw, div_hold, wb_clash, accept;
  logic [3:0]  lat, lat_p1;
  logic [31:0] pend_set, pend_clr;

  assign legal   = (dec_ena != 4'd0) && (dec_ena <= 4'd9);
  assign use_rs2 = !(dec_ena == 4'b0100 || dec_ena == 4'b0111 || dec_ena == 4'b1000);
  assign use_rs3 = (dec_ena == 4'b1001);
  assign is_div  = (dec_ena == 4'b0011 || dec_ena == 4'b0100);
  assign lat     = lat_of(dec_ena);
  assign lat_p1  = lat + 4'd1;

  assign raw = pend[dec_rs1] || (use_rs2 && pend[dec_rs2]) || (use_rs3 && pend[dec_rs3]);
  assign waw = dec_wr_en && pend[dec_rd];
  // div_cnt==1 is the unit's last busy cycle; a div accepted now issues
  // on the following cycle, so only a count above 1 blocks it.
  assign div_hold = is_div && (div_cnt > 4'd1);
  // After this edge's shift, slot[lat] holds what is in slot[lat+1] now.
  assign wb_clash = dec_wr_en && (lat < 4'd15) && slot_v[lat_p1];

  assign dec_ready = !legal || !(raw || waw || div_hold || wb_clash);
  assign accept    = dec_valid && dec_ready && !flush;

  assign pend_set = (accept && legal && dec_wr_en) ? (32'd1 << dec_rd) : 32'd0;
  assign pend_clr = slot_v[0] ? (32'd1 << slot_rd[0]) : 32'd0;

  assign wb_valid = slot_v[0];
  assign wb_rd    = slot_rd[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      slot_v    <= '0;
      for (int i = 0; i < 16; i++) slot_rd[i] <= '0;
      div_cnt   <= '0;
      iss_valid <= 1'b0;
      illegal   <= 1'b0;
      iss_ena   <= '0;
      iss_op    <= 1'b0;
      iss_sel1  <= '0;
      iss_sel2  <= '0;
      iss_rm    <= '0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rs3   <= '0;
      iss_rd    <= '0;
    end else if (flush) begin
      pend      <= '0;
      slot_v    <= '0;
      for (int i = 0; i < 16; i++) slot_rd[i] <= '0;
      div_cnt   <= '0;
      iss_valid <= 1'b0;
      illegal   <= 1'b0;
      iss_ena   <= '0;
      iss_op    <= 1'b0;
      iss_sel1  <= '0;
      iss_sel2  <= '0;
      iss_rm    <= '0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rs3   <= '0;
      iss_rd    <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;

      for (int i = 0; i < 15; i++) begin
        slot_v[i]  <= slot_v[i+1];
        slot_rd[i] <= slot_rd[i+1];
      end
      slot_v[15]  <= 1'b0;
      slot_rd[15] <= '0;
      // Overrides the shift for the slot this instruction writes back from.
      if (accept && legal && dec_wr_en) begin
        slot_v[lat]  <= 1'b1;
        slot_rd[lat] <= dec_rd;
      end

      if (accept && legal && is_div) div_cnt <= 4'(DIV_LAT);
      else if (div_cnt != 4'd0)      div_cnt <= div_cnt - 4'd1;

      iss_valid <= accept && legal;
      illegal   <= accept && !legal;
      if (accept && legal) begin
        iss_ena  <= dec_ena;
        iss_op   <= dec_op;
        iss_sel1 <= dec_sel1;
        iss_sel2 <= dec_sel2;
        iss_rm   <= dec_rm;
        iss_rs1  <= dec_rs1;
        iss_rs2  <= dec_rs2;
        iss_rs3  <= dec_rs3;
        iss_rd   <= dec_rd;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       dec_valid = 1'b0;
  logic       dec_ready;
  logic [3:0] dec_ena = '0;
  logic       dec_op = 1'b0;
  logic [1:0] dec_sel1 = '0;
  logic [2:0] dec_sel2 = '0;
  logic [2:0] dec_rm = '0;
  logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rs3 = '0, dec_rd = '0;
  logic       dec_wr_en = 1'b0;
  logic       iss_valid;
  logic [3:0] iss_ena;
  logic       iss_op;
  logic [1:0] iss_sel1;
  logic [2:0] iss_sel2, iss_rm;
  logic [4:0] iss_rs1, iss_rs2, iss_rs3, iss_rd;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       illegal;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.MUL_LAT(3), .FMA_LAT(4), .DIV_LAT(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_ena(dec_ena), .dec_op(dec_op), .dec_sel1(dec_sel1), .dec_sel2(dec_sel2),
    .dec_rm(dec_rm), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3),
    .dec_rd(dec_rd), .dec_wr_en(dec_wr_en),
    .iss_valid(iss_valid), .iss_ena(iss_ena), .iss_op(iss_op), .iss_sel1(iss_sel1),
    .iss_sel2(iss_sel2), .iss_rm(iss_rm), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rs3(iss_rs3), .iss_rd(iss_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .illegal(illegal)
  );

  task automatic drive(input logic v, input logic [3:0] e, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                       input logic w);
    dec_valid = v; dec_ena = e; dec_rd = rd;
    dec_rs1 = r1; dec_rs2 = r2; dec_rs3 = r3; dec_wr_en = w;
    dec_op = 1'b1; dec_sel1 = 2'b10; dec_sel2 = 3'b101; dec_rm = 3'b011;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    drive(0, 4'd0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 4'b0001, 5'd3, 5'd1, 5'd2, 5'd0, 1);
    repeat (2) @(posedge clk);
    #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", dec_ready); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL rst_iss_valid got=%0b exp=0", iss_valid); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%0b exp=0", illegal); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0b exp=0", wb_valid); end
    total++; if (wb_rd !== 5'd0) begin bad++; $display("FAIL rst_wb_rd got=%0d exp=0", wb_rd); end
    total++; if (iss_rd !== 5'd0 || iss_ena !== 4'd0) begin bad++; $display("FAIL rst_iss_fields got=%0d/%0d exp=0/0", iss_rd, iss_ena); end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    step(); drive(1, 4'b0001, 5'd5, 5'd1, 5'd2, 5'd0, 1); #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL basic_accept got=%0b exp=1", dec_ready); end
    for (int c = 1; c <= 5; c++) begin
      step();
      total++; if (iss_valid !== (c == 1)) begin bad++; $display("FAIL basic_iss_valid c=%0d got=%0b exp=%0b", c, iss_valid, c == 1); end
      if (c == 1) begin
        total++;
        if (iss_rd !== 5'd5 || iss_rs1 !== 5'd1 || iss_rs2 !== 5'd2 || iss_ena !== 4'd1 ||
            iss_op !== 1'b1 || iss_sel1 !== 2'b10 || iss_sel2 !== 3'b101 || iss_rm !== 3'b011) begin
          bad++; $display("FAIL basic_fields got rd=%0d rs1=%0d rs2=%0d ena=%0d rm=%0d exp 5 1 2 1 3", iss_rd, iss_rs1, iss_rs2, iss_ena, iss_rm);
        end
      end
      total++; if (wb_valid !== (c == 3)) begin bad++; $display("FAIL basic_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, c == 3); end
      if (c == 3) begin
        total++; if (wb_rd !== 5'd5) begin bad++; $display("FAIL basic_wb_rd got=%0d exp=5", wb_rd); end
      end
      drive(0, 4'b0001, 5'd0, 5'd5, 5'd0, 5'd0, 0); #1;
      total++; if (dec_ready !== (c >= 4)) begin bad++; $display("FAIL basic_pending c=%0d got=%0b exp=%0b", c, dec_ready, c >= 4); end
    end
  endtask

  task automatic test_raw();
    do_reset();
    step(); drive(1, 4'b0001, 5'd5, 5'd1, 5'd2, 5'd0, 1);
    for (int c = 1; c <= 9; c++) begin
      step();
      total++; if (wb_valid !== (c == 3 || c == 8)) begin bad++; $display("FAIL raw_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, c == 3 || c == 8); end
      if (c == 3 || c == 8) begin
        total++; if (wb_rd !== ((c == 3) ? 5'd5 : 5'd6)) begin bad++; $display("FAIL raw_wb_rd c=%0d got=%0d", c, wb_rd); end
      end
      if (c <= 4) begin
        drive(1, 4'b0010, 5'd6, 5'd5, 5'd0, 5'd0, 1); #1;
        total++; if (dec_ready !== (c == 4)) begin bad++; $display("FAIL raw_ready c=%0d got=%0b exp=%0b", c, dec_ready, c == 4); end
      end else drive(0, 4'd0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_wb_conflict();
    do_reset();
    step(); drive(1, 4'b0010, 5'd3, 5'd1, 5'd2, 5'd0, 1);
    for (int c = 1; c <= 6; c++) begin
      step();
      total++; if (wb_valid !== (c == 4 || c == 5)) begin bad++; $display("FAIL wbc_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, c == 4 || c == 5); end
      if (c == 4 || c == 5) begin
        total++; if (wb_rd !== ((c == 4) ? 5'd3 : 5'd4)) begin bad++; $display("FAIL wbc_wb_rd c=%0d got=%0d", c, wb_rd); end
      end
      if (c <= 2) begin
        drive(1, 4'b0001, 5'd4, 5'd8, 5'd9, 5'd0, 1); #1;
        total++; if (dec_ready !== (c == 2)) begin bad++; $display("FAIL wbc_ready c=%0d got=%0b exp=%0b", c, dec_ready, c == 2); end
      end else drive(0, 4'd0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_div_busy();
    do_reset();
    step(); drive(1, 4'b0011, 5'd1, 5'd2, 5'd3, 5'd0, 1);
    for (int c = 1; c <= 18; c++) begin
      step();
      total++; if (wb_valid !== (c == 9 || c == 17)) begin bad++; $display("FAIL div_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, c == 9 || c == 17); end
      if (c == 9 || c == 17) begin
        total++; if (wb_rd !== ((c == 9) ? 5'd1 : 5'd2)) begin bad++; $display("FAIL div_wb_rd c=%0d got=%0d", c, wb_rd); end
      end
      if (c <= 8) begin
        // rs2=1 is pending until cycle 9, but sqrt does not read rs2
        drive(1, 4'b0100, 5'd2, 5'd4, 5'd1, 5'd0, 1); #1;
        total++; if (dec_ready !== (c == 8)) begin bad++; $display("FAIL div_ready c=%0d got=%0b exp=%0b", c, dec_ready, c == 8); end
      end else drive(0, 4'd0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    step(); drive(1, 4'b0010, 5'd10, 5'd1, 5'd2, 5'd0, 1);
    step();
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL ill_mul_issue got=%0b exp=1", iss_valid); end
    drive(1, 4'b1011, 5'd10, 5'd10, 5'd0, 5'd0, 1); #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL ill_ready got=%0b exp=1", dec_ready); end
    step();
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_pulse got=%0b exp=1", illegal); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL ill_no_issue got=%0b exp=0", iss_valid); end
    total++; if (iss_ena !== 4'b0010) begin bad++; $display("FAIL ill_iss_hold got=%0d exp=2", iss_ena); end
    drive(1, 4'b0001, 5'd11, 5'd1, 5'd2, 5'd0, 0); #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL nowr_ready got=%0b exp=1", dec_ready); end
    step();
    total++; if (iss_valid !== 1'b1 || iss_rd !== 5'd11) begin bad++; $display("FAIL nowr_issue got=%0b/%0d exp=1/11", iss_valid, iss_rd); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_one_cycle got=%0b exp=0", illegal); end
    drive(0, 4'b0001, 5'd0, 5'd11, 5'd0, 5'd0, 0); #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL nowr_no_pend got=%0b exp=1", dec_ready); end
    drive(0, 4'b0001, 5'd0, 5'd10, 5'd0, 5'd0, 0); #1;
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL ill_keeps_pend got=%0b exp=0", dec_ready); end
    drive(0, 4'd0, 0, 0, 0, 0, 0);
    for (int c = 4; c <= 8; c++) begin
      step();
      total++; if (wb_valid !== (c == 4)) begin bad++; $display("FAIL ill_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, c == 4); end
      if (c == 4) begin
        total++; if (wb_rd !== 5'd10) begin bad++; $display("FAIL ill_wb_rd got=%0d exp=10", wb_rd); end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(); drive(1, 4'b1001, 5'd7, 5'd1, 5'd2, 5'd3, 1);
    step(); drive(0, 4'd0, 0, 0, 0, 0, 0);
    step(); flush = 1'b1;
    for (int c = 3; c <= 7; c++) begin
      step();
      flush = 1'b0;
      if (c == 3) begin
        total++; if (iss_valid !== 1'b0 || iss_rd !== 5'd0 || iss_ena !== 4'd0) begin bad++; $display("FAIL flush_clears got=%0b/%0d/%0d exp=0/0/0", iss_valid, iss_rd, iss_ena); end
        drive(1, 4'b0001, 5'd8, 5'd7, 5'd0, 5'd0, 1); #1;
        total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0b exp=1", dec_ready); end
      end else drive(0, 4'd0, 0, 0, 0, 0, 0);
      if (c == 4) begin
        total++; if (iss_valid !== 1'b1 || iss_rs1 !== 5'd7) begin bad++; $display("FAIL flush_next_issue got=%0b/%0d exp=1/7", iss_valid, iss_rs1); end
      end
      total++; if (wb_valid !== (c == 6)) begin bad++; $display("FAIL flush_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, c == 6); end
      if (c == 6) begin
        total++; if (wb_rd !== 5'd8) begin bad++; $display("FAIL flush_wb_rd got=%0d exp=8", wb_rd); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); drive(1, 4'b1001, 5'd7, 5'd1, 5'd2, 5'd3, 1);
    step(); drive(0, 4'b0001, 5'd0, 5'd7, 5'd0, 5'd0, 0);
    total++; if (iss_valid !== 1'b1 || iss_rd !== 5'd7) begin bad++; $display("FAIL rmid_issue got=%0b/%0d exp=1/7", iss_valid, iss_rd); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (iss_valid !== 1'b0 || iss_rd !== 5'd0 || iss_ena !== 4'd0) begin bad++; $display("FAIL rmid_async got=%0b/%0d/%0d exp=0/0/0", iss_valid, iss_rd, iss_ena); end
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0b exp=1", dec_ready); end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_wb c=%0d got=%0b exp=0", c, wb_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_wb_conflict();
    test_div_busy();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue and hazard-control stage for the PSIMD DLFloat FPU. It sits directly downstream of the instruction decoder and accepts one decoded instruction per cycle over a valid/ready handshake. It holds the instruction back on register (RAW/WAW) hazards, on a busy divide/sqrt unit, and on writeback-port conflicts. Each accepted instruction becomes a registered one-cycle issue pulse to the functional units, and its writeback is sequenced so the single register-file write port sees at most one write per cycle.

## Interface
Parameters:
- MUL_LAT, 3, multiply latency in cycles (1..15)
- FMA_LAT, 4, fused multiply-add/sub latency (1..15)
- DIV_LAT, 8, divide and sqrt latency; the unit is non-pipelined (1..15)

Ports:
- clk  in  1  clock; one clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; drops all in-flight state
- dec_valid  in  1  decoded instruction present
- dec_ready  out  1  stage can accept this cycle
- dec_ena  in  4  unit select from decoder
- dec_op, dec_sel1[1:0], dec_sel2[2:0], dec_rm[2:0]  in  sub-op fields, passed through
- dec_rs1, dec_rs2, dec_rs3, dec_rd  in  5 each  register addresses
- dec_wr_en  in  1  instruction writes rd
- iss_valid  out  1  one-cycle issue pulse
- iss_ena, iss_op, iss_sel1, iss_sel2, iss_rm, iss_rs1, iss_rs2, iss_rs3, iss_rd  out  registered copies of the accepted fields
- wb_valid  out  1  register-file write strobe
- wb_rd  out  5  write address
- illegal  out  1  one-cycle pulse: illegal ena consumed

## Operation
- Latency per ena: 0001 add/sub 2; 0010 mul MUL_LAT; 0011 div DIV_LAT; 0100 sqrt DIV_LAT; 0101 sign-inject 1; 0110 min/max/compare 1; 0111 int→float 2; 1000 float→int 2; 1001 fma/fms FMA_LAT.
- Illegal ena values are 0000 and 1010–1111. An illegal instruction is always accepted (dec_ready=1 regardless of hazards). On acceptance: illegal pulses the next cycle, with no issue, no writeback and no scoreboard change.
- Source use: rs1 is used by every legal ena. rs2 is used by every legal ena except 0100, 0111 and 1000. rs3 is used only by 1001.
- Scoreboard: 32-bit pending mask.
  - A bit is set when an instruction with dec_wr_en=1 is accepted.
  - The bit is cleared at the end of that instruction's wb_valid cycle.
- dec_ready=0 when any of the following holds for the offered instruction:
  - any used source is pending (RAW);
  - dec_wr_en=1 and rd is pending (WAW);
  - ena is 0011/0100 and the div unit is busy;
  - dec_wr_en=1 and another in-flight instruction already owns the writeback cycle this one would use.
- Div/sqrt unit: busy from its issue cycle I through I+DIV_LAT−1.
- Writeback timeline: a depth-16 slot shift register holding {valid, rd}; each slot is indexed by cycles-until-writeback.
- Pass-through fields are never altered.

## Timing
- Reset values (also after flush): dec_ready=1 (combinational, no hazards), iss_valid=0, illegal=0, wb_valid=0, all iss_* fields=0, wb_rd=0, scoreboard=0, div busy=0, all slots invalid.
- Acceptance at cycle T (dec_valid & dec_ready) → iss_valid high in cycle T+1 → wb_valid high with wb_rd=rd in cycle T+1+L.
- A dependent instruction can be accepted no earlier than cycle T+2+L; its source reads in cycle T+3+L see the written value. There is no bypass.
- Back-to-back independent instructions: one accepted per cycle, throughput 1.
- Two divides: the second is accepted no earlier than T+DIV_LAT.
- dec_ready is combinational from the dec_* inputs and state. Upstream must hold its fields stable while dec_valid=1 and dec_ready=0.
- flush takes priority over acceptance in the same cycle: the offered instruction is dropped, and every output/state returns to its reset value at the next edge.
- Asynchronous reset mid-operation abandons pending writebacks; no wb_valid is produced for them.
- A scoreboard clear and a new set of the same bit in the same cycle cannot occur, because the WAW stall prevents it.

## Test plan
- Reset, then add rd=5 rs1=1 rs2=2 accepted at cycle 0 → iss_valid in cycle 1, wb_valid with wb_rd=5 in cycle 3, pending[5] clear from cycle 4.
- RAW: add rd=5, then mul rs1=5 offered from cycle 1 → dec_ready=0 in cycles 1–3, mul accepted in cycle 4, wb rd of mul in cycle 4+1+3=8.
- WB conflict: mul rd=3 accepted at cycle 0 (wb cycle 4), then add rd=4 offered at cycle 1 (would also wb in cycle 4) → stalled one cycle, accepted at cycle 2, wb in cycle 5; no cycle has two writes.
- Div busy: div rd=1 at cycle 0, sqrt rd=2 offered from cycle 1 → accepted at cycle 8; wb for rd=1 in cycle 9, for rd=2 in cycle 17.
- Illegal and dec_wr_en=0: ena=1011 → illegal pulse, no iss_valid/wb_valid; an instruction with dec_wr_en=0 issues but produces no wb_valid and does not set the scoreboard.
- Flush/reset: fma rd=7 accepted, flush asserted two cycles later → no wb_valid for rd=7, and an instruction reading rs1=7 is accepted the next cycle; repeat with rst_n pulsed low mid-flight → every output returns to its reset value immediately.
